// File: rtl/connection_block_cfg.sv
// Unidirectional island-style connection block with a daisy-chained, double-buffered
// configuration store (serial shadow chain + active register) and optional input pipeline.
module connection_block_cfg #(
  parameter int WS         = 8,
  parameter int WD         = 8,
  parameter int WG         = 3,
  parameter int CLBIN      = 6,
  parameter int CLBOUT     = 1,
  parameter int CARRY      = 1,
  parameter int CLBOS      = 2,
  parameter int CLBOS_BIAS = 0,
  parameter int CLBOD      = 2,
  parameter int CLBOD_BIAS = 0,
  parameter int CLBX       = 1,
  parameter int CHAIN_W    = 8,
  parameter int REG_IN     = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WS-1:0]                 single0_in,
  input  logic [WS-1:0]                 single1_in,
  output logic [WS-1:0]                 single0_out,
  output logic [WS-1:0]                 single1_out,
  input  logic [WD-1:0]                 double0_in,
  input  logic [WD-1:0]                 double1_in,
  output logic [WD-1:0]                 double0_out,
  output logic [WD-1:0]                 double1_out,
  input  logic [(WG > 0 ? WG : 1)-1:0]  global_lines,
  input  logic [CLBOUT-1:0]             clb0_output,
  input  logic [CLBOUT-1:0]             clb1_output,
  input  logic [CARRY-1:0]              clb0_cout,
  input  logic [CARRY-1:0]              clb1_cout,
  output logic [CLBIN-1:0]              clb0_input,
  output logic [CLBIN-1:0]              clb1_input,
  output logic [CARRY-1:0]              clb0_cin,
  output logic [CARRY-1:0]              clb1_cin,
  input  logic [CHAIN_W-1:0]            cfg_in,
  input  logic                          cfg_en,
  output logic [CHAIN_W-1:0]            cfg_out,
  input  logic                          cfg_commit,
  output logic                          cfg_ready,
  output logic                          cfg_err
);

  localparam int N_IN       = 2*(WS+WD) + WG + CLBX*CLBOUT;
  localparam int SEL_IN     = $clog2(N_IN);
  localparam int N_OUT      = 2*CLBOUT + 1;
  localparam int SEL_OUT    = $clog2(N_OUT);
  localparam int CONF_WIDTH = 2*CLBIN*SEL_IN + 2*SEL_OUT*(CLBOS+CLBOD);
  localparam int BEATS      = (CONF_WIDTH + CHAIN_W - 1) / CHAIN_W;
  localparam int PAD        = BEATS * CHAIN_W;
  localparam int CNT_W      = $clog2(BEATS + 1);
  localparam int HALF_D     = WD / 2;
  localparam int STAP       = (CLBOS_BIAS * CLBOS) % WS;
  localparam int DTAP       = (CLBOD_BIAS * CLBOD) % HALF_D;

  localparam int OFF_C0 = 0;
  localparam int OFF_C1 = CLBIN * SEL_IN;
  localparam int OFF_S0 = 2 * CLBIN * SEL_IN;
  localparam int OFF_S1 = OFF_S0 + CLBOS * SEL_OUT;
  localparam int OFF_D0 = OFF_S1 + CLBOS * SEL_OUT;
  localparam int OFF_D1 = OFF_D0 + CLBOD * SEL_OUT;
  localparam int OFF_G  = 2 * (WS + WD);
  localparam int OFF_X  = OFF_G + WG;

  localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(BEATS);

  logic [PAD-1:0]        shadow;
  logic [CONF_WIDTH-1:0] active;
  logic [CNT_W-1:0]      count;
  logic [CNT_W-1:0]      count_next;
  logic                  ready_q;
  logic                  err_q;
  logic                  commit_ok;

  logic [N_IN-1:0]       vec0;
  logic [N_IN-1:0]       vec1;
  logic [CLBIN-1:0]      in0_c;
  logic [CLBIN-1:0]      in1_c;
  logic [2*CLBOUT-1:0]   clbs;

  // Out-of-range selects fall through to the 0 default.
  function automatic logic imux(input logic [SEL_IN-1:0] sel, input logic [N_IN-1:0] vec);
    imux = 1'b0;
    for (int j = 0; j < N_IN; j++)
      if (sel == SEL_IN'(j)) imux = vec[j];
  endfunction

  function automatic logic omux(input logic [SEL_OUT-1:0] sel, input logic straight,
                                input logic [2*CLBOUT-1:0] src);
    omux = 1'b0;
    if (sel == '0) omux = straight;
    for (int j = 1; j < N_OUT; j++)
      if (sel == SEL_OUT'(j)) omux = src[j-1];
  endfunction

  // A commit is only legal with a full shadow and no shift in the same cycle.
  assign commit_ok = cfg_commit & ready_q & ~cfg_en;

  always_comb begin
    count_next = count;
    if (commit_ok)
      count_next = '0;
    else if (cfg_en && count != BEATS_C)
      count_next = count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (cfg_en)
        shadow <= (shadow << CHAIN_W) | PAD'(cfg_in);
      if (commit_ok)
        active <= shadow[CONF_WIDTH-1:0];
      if (cfg_commit && !commit_ok)
        err_q <= 1'b1;
      count   <= count_next;
      ready_q <= (count_next == BEATS_C);
    end
  end

  assign cfg_out   = shadow[PAD-1 -: CHAIN_W];
  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;

  assign clb1_cin = clb0_cout;
  assign clb0_cin = clb1_cout;

  // Each CLB sees the shared tracks/globals, then the opposite CLB's outputs.
  always_comb begin
    vec0 = '0;
    vec0[0 +: WS]          = single0_in;
    vec0[WS +: WS]         = single1_in;
    vec0[2*WS +: WD]       = double0_in;
    vec0[2*WS+WD +: WD]    = double1_in;
    for (int i = 0; i < WG; i++)
      vec0[OFF_G + i] = global_lines[i];
    vec1 = vec0;
    for (int i = 0; i < CLBX*CLBOUT; i++) begin
      vec0[OFF_X + i] = clb1_output[i];
      vec1[OFF_X + i] = clb0_output[i];
    end
  end

  always_comb begin
    in0_c = '0;
    in1_c = '0;
    for (int i = 0; i < CLBIN; i++) begin
      in0_c[i] = imux(active[OFF_C0 + i*SEL_IN +: SEL_IN], vec0);
      in1_c[i] = imux(active[OFF_C1 + i*SEL_IN +: SEL_IN], vec1);
    end
  end

  assign clbs = {clb1_output, clb0_output};

  always_comb begin
    single1_out = single0_in;
    single0_out = single1_in;
    for (int k = 0; k < CLBOS; k++) begin
      single1_out[(STAP+k)%WS] = omux(active[OFF_S0 + k*SEL_OUT +: SEL_OUT],
                                      single0_in[(STAP+k)%WS], clbs);
      single0_out[(STAP+k)%WS] = omux(active[OFF_S1 + k*SEL_OUT +: SEL_OUT],
                                      single1_in[(STAP+k)%WS], clbs);
    end
  end

  // Only the lower double half is tappable; the upper half always passes straight.
  always_comb begin
    double1_out = double0_in;
    double0_out = double1_in;
    for (int k = 0; k < CLBOD; k++) begin
      double1_out[(DTAP+k)%HALF_D] = omux(active[OFF_D0 + k*SEL_OUT +: SEL_OUT],
                                          double0_in[(DTAP+k)%HALF_D], clbs);
      double0_out[(DTAP+k)%HALF_D] = omux(active[OFF_D1 + k*SEL_OUT +: SEL_OUT],
                                          double1_in[(DTAP+k)%HALF_D], clbs);
    end
  end

  generate
    if (REG_IN != 0) begin : g_reg_in
      always_ff @(posedge clk) begin
        if (rst) begin
          clb0_input <= '0;
          clb1_input <= '0;
        end else begin
          clb0_input <= in0_c;
          clb1_input <= in1_c;
        end
      end
    end else begin : g_comb_in
      assign clb0_input = in0_c;
      assign clb1_input = in1_c;
    end
  endgenerate

endmodule

// File: tb/tb_connection_block_cfg.sv
// Scoreboard bench for connection_block_cfg: default, output-bias and registered-input instances
// share all stimulus, including the configuration chain.
module tb_connection_block_cfg;

  localparam int CW = 88;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] single0_in, single1_in, double0_in, double1_in;
  logic [2:0] global_lines;
  logic [0:0] clb0_output, clb1_output, clb0_cout, clb1_cout;
  logic [7:0] cfg_in;
  logic       cfg_en, cfg_commit;

  logic [7:0] a_single0_out, a_single1_out, a_double0_out, a_double1_out, a_cfg_out;
  logic [5:0] a_clb0_input, a_clb1_input;
  logic [0:0] a_clb0_cin, a_clb1_cin;
  logic       a_cfg_ready, a_cfg_err;
  logic [7:0] b_single0_out, b_single1_out, b_double0_out, b_double1_out, b_cfg_out;
  logic [5:0] b_clb0_input, b_clb1_input;
  logic [0:0] b_clb0_cin, b_clb1_cin;
  logic       b_cfg_ready, b_cfg_err;
  logic [7:0] r_single0_out, r_single1_out, r_double0_out, r_double1_out, r_cfg_out;
  logic [5:0] r_clb0_input, r_clb1_input;
  logic [0:0] r_clb0_cin, r_clb1_cin;
  logic       r_cfg_ready, r_cfg_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] ev;
  string       en;

  always #5 clk = ~clk;

  connection_block_cfg dut_a (
    .clk(clk), .rst(rst),
    .single0_in(single0_in), .single1_in(single1_in),
    .single0_out(a_single0_out), .single1_out(a_single1_out),
    .double0_in(double0_in), .double1_in(double1_in),
    .double0_out(a_double0_out), .double1_out(a_double1_out),
    .global_lines(global_lines),
    .clb0_output(clb0_output), .clb1_output(clb1_output),
    .clb0_cout(clb0_cout), .clb1_cout(clb1_cout),
    .clb0_input(a_clb0_input), .clb1_input(a_clb1_input),
    .clb0_cin(a_clb0_cin), .clb1_cin(a_clb1_cin),
    .cfg_in(cfg_in), .cfg_en(cfg_en), .cfg_out(a_cfg_out),
    .cfg_commit(cfg_commit), .cfg_ready(a_cfg_ready), .cfg_err(a_cfg_err)
  );

  connection_block_cfg #(.CLBOS_BIAS(3)) dut_b (
    .clk(clk), .rst(rst),
    .single0_in(single0_in), .single1_in(single1_in),
    .single0_out(b_single0_out), .single1_out(b_single1_out),
    .double0_in(double0_in), .double1_in(double1_in),
    .double0_out(b_double0_out), .double1_out(b_double1_out),
    .global_lines(global_lines),
    .clb0_output(clb0_output), .clb1_output(clb1_output),
    .clb0_cout(clb0_cout), .clb1_cout(clb1_cout),
    .clb0_input(b_clb0_input), .clb1_input(b_clb1_input),
    .clb0_cin(b_clb0_cin), .clb1_cin(b_clb1_cin),
    .cfg_in(cfg_in), .cfg_en(cfg_en), .cfg_out(b_cfg_out),
    .cfg_commit(cfg_commit), .cfg_ready(b_cfg_ready), .cfg_err(b_cfg_err)
  );

  connection_block_cfg #(.REG_IN(1)) dut_r (
    .clk(clk), .rst(rst),
    .single0_in(single0_in), .single1_in(single1_in),
    .single0_out(r_single0_out), .single1_out(r_single1_out),
    .double0_in(double0_in), .double1_in(double1_in),
    .double0_out(r_double0_out), .double1_out(r_double1_out),
    .global_lines(global_lines),
    .clb0_output(clb0_output), .clb1_output(clb1_output),
    .clb0_cout(clb0_cout), .clb1_cout(clb1_cout),
    .clb0_input(r_clb0_input), .clb1_input(r_clb1_input),
    .clb0_cin(r_clb0_cin), .clb1_cin(r_clb1_cin),
    .cfg_in(cfg_in), .cfg_en(cfg_en), .cfg_out(r_cfg_out),
    .cfg_commit(cfg_commit), .cfg_ready(r_cfg_ready), .cfg_err(r_cfg_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string n, input logic [31:0] v);
    name_q.push_back(n);
    exp_q.push_back(v);
  endtask

  task automatic pop_exp(output string n, output logic [31:0] v);
    n = name_q.pop_front();
    v = exp_q.pop_front();
  endtask

  // Beat b carries word bits [CW-1-8b -: 8], so the first beat ends at the chain top.
  task automatic shift_beats(input logic [CW-1:0] w, input int first, input int n);
    for (int b = first; b < first + n; b++) begin
      cfg_in = w[CW-1-8*b -: 8];
      cfg_en = 1'b1;
      tick();
    end
    cfg_en = 1'b0;
    cfg_in = 8'h00;
  endtask

  task automatic do_commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_en = 1'b1; cfg_commit = 1'b1; cfg_in = 8'hFF;
    single0_in = 8'hA5; double1_in = 8'h3C; clb0_cout = 1'b1; clb1_cout = 1'b0;
    push_exp("rst_single1_out", 32'hA5);
    push_exp("rst_double0_out", 32'h3C);
    push_exp("rst_clb0_input", 32'h3F);
    push_exp("rst_clb1_input", 32'h3F);
    push_exp("rst_cfg_ready", 32'h0);
    push_exp("rst_cfg_err", 32'h0);
    push_exp("rst_cfg_out", 32'h0);
    push_exp("rst_reg_in_zero", 32'h0);
    push_exp("carry_clb1_cin", 32'h1);
    push_exp("carry_clb0_cin", 32'h0);
    tick();
    pop_exp(en, ev); checks++; if (32'(a_single1_out) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_single1_out, ev); end
    pop_exp(en, ev); checks++; if (32'(a_double0_out) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_double0_out, ev); end
    pop_exp(en, ev); checks++; if (32'(a_clb0_input) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_clb0_input, ev); end
    pop_exp(en, ev); checks++; if (32'(a_clb1_input) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_clb1_input, ev); end
    pop_exp(en, ev); checks++; if (32'(a_cfg_ready) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_ready, ev); end
    pop_exp(en, ev); checks++; if (32'(a_cfg_err) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_err, ev); end
    pop_exp(en, ev); checks++; if (32'(a_cfg_out) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_out, ev); end
    pop_exp(en, ev); checks++; if (32'(r_clb0_input) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, r_clb0_input, ev); end
    pop_exp(en, ev); checks++; if (32'(a_clb1_cin) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_clb1_cin, ev); end
    pop_exp(en, ev); checks++; if (32'(a_clb0_cin) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_clb0_cin, ev); end
    rst = 1'b0; cfg_en = 1'b0; cfg_commit = 1'b0; cfg_in = 8'h00;
    push_exp("rst_reg_in_follow", 32'h3F);
    push_exp("rst_err_after", 32'h0);
    tick();
    pop_exp(en, ev); checks++; if (32'(r_clb0_input) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, r_clb0_input, ev); end
    pop_exp(en, ev); checks++; if (32'(a_cfg_err) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_err, ev); end
  endtask

  task automatic test_commit();
    logic [CW-1:0] w;
    w = '0;
    w[5:0]   = 6'd35;
    w[87:80] = 8'hF0;
    single0_in = 8'h00; double0_in = 8'h00; double1_in = 8'hFF; clb1_output = 1'b1;
    push_exp("load_ready_b10", 32'h0);
    shift_beats(w, 0, 10);
    pop_exp(en, ev); checks++; if (32'(a_cfg_ready) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_ready, ev); end
    push_exp("load_ready_b11", 32'h1);
    push_exp("load_cfg_out", 32'hF0);
    push_exp("load_no_glitch", 32'h00);
    shift_beats(w, 10, 1);
    pop_exp(en, ev); checks++; if (32'(a_cfg_ready) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_ready, ev); end
    pop_exp(en, ev); checks++; if (32'(a_cfg_out) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_out, ev); end
    pop_exp(en, ev); checks++; if (32'(a_clb0_input) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_clb0_input, ev); end
    push_exp("commit_ready", 32'h0);
    push_exp("commit_clb0_input", 32'h01);
    push_exp("commit_clb1_input", 32'h00);
    push_exp("commit_double0_out", 32'hFC);
    push_exp("commit_shadow_kept", 32'hF0);
    push_exp("commit_err", 32'h0);
    do_commit();
    pop_exp(en, ev); checks++; if (32'(a_cfg_ready) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_ready, ev); end
    pop_exp(en, ev); checks++; if (32'(a_clb0_input) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_clb0_input, ev); end
    pop_exp(en, ev); checks++; if (32'(a_clb1_input) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_clb1_input, ev); end
    pop_exp(en, ev); checks++; if (32'(a_double0_out) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_double0_out, ev); end
    pop_exp(en, ev); checks++; if (32'(a_cfg_out) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_out, ev); end
    pop_exp(en, ev); checks++; if (32'(a_cfg_err) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_err, ev); end
  endtask

  task automatic test_bias();
    logic [CW-1:0] w;
    w = '0;
    w[73:72] = 2'd2;
    single0_in = 8'h00; single1_in = 8'h00; clb1_output = 1'b1;
    shift_beats(w, 0, 11);
    push_exp("bias_b_single1_out", 32'h40);
    push_exp("bias_a_single1_out", 32'h01);
    do_commit();
    pop_exp(en, ev); checks++; if (32'(b_single1_out) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, b_single1_out, ev); end
    pop_exp(en, ev); checks++; if (32'(a_single1_out) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_single1_out, ev); end
    single0_in = 8'h80;
    push_exp("bias_b_straight", 32'hC0);
    push_exp("bias_a_straight", 32'h81);
    #1;
    pop_exp(en, ev); checks++; if (32'(b_single1_out) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, b_single1_out, ev); end
    pop_exp(en, ev); checks++; if (32'(a_single1_out) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_single1_out, ev); end
  endtask

  task automatic test_illegal_commit();
    logic [CW-1:0] w;
    w = '0;
    w[5:0] = 6'd8;
    single1_in = 8'hFF;
    shift_beats(w, 0, 5);
    push_exp("early_err", 32'h1);
    push_exp("early_ready", 32'h0);
    push_exp("early_active_kept", 32'h00);
    push_exp("early_bias_kept", 32'hC0);
    do_commit();
    pop_exp(en, ev); checks++; if (32'(a_cfg_err) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_err, ev); end
    pop_exp(en, ev); checks++; if (32'(a_cfg_ready) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_ready, ev); end
    pop_exp(en, ev); checks++; if (32'(a_clb0_input) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_clb0_input, ev); end
    pop_exp(en, ev); checks++; if (32'(b_single1_out) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, b_single1_out, ev); end
    shift_beats(w, 5, 6);
    push_exp("en_commit_err", 32'h1);
    push_exp("en_commit_ready_sat", 32'h1);
    push_exp("en_commit_active_kept", 32'h00);
    push_exp("en_commit_bias_kept", 32'hC0);
    cfg_en = 1'b1; cfg_commit = 1'b1; cfg_in = 8'h00;
    tick();
    cfg_en = 1'b0; cfg_commit = 1'b0;
    pop_exp(en, ev); checks++; if (32'(a_cfg_err) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_err, ev); end
    pop_exp(en, ev); checks++; if (32'(a_cfg_ready) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_ready, ev); end
    pop_exp(en, ev); checks++; if (32'(a_clb0_input) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_clb0_input, ev); end
    pop_exp(en, ev); checks++; if (32'(b_single1_out) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, b_single1_out, ev); end
  endtask

  task automatic test_reset_midload();
    logic [CW-1:0] w;
    w = '0;
    w[53:48] = 6'd16;
    single0_in = 8'h01;
    shift_beats(w, 0, 7);
    push_exp("mid_ready", 32'h0);
    push_exp("mid_err", 32'h0);
    push_exp("mid_cfg_out", 32'h00);
    push_exp("mid_b_straight", 32'h01);
    push_exp("mid_clb0_input", 32'h3F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pop_exp(en, ev); checks++; if (32'(a_cfg_ready) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_ready, ev); end
    pop_exp(en, ev); checks++; if (32'(a_cfg_err) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_err, ev); end
    pop_exp(en, ev); checks++; if (32'(a_cfg_out) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_out, ev); end
    pop_exp(en, ev); checks++; if (32'(b_single1_out) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, b_single1_out, ev); end
    pop_exp(en, ev); checks++; if (32'(a_clb0_input) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_clb0_input, ev); end
    single0_in = 8'h00; double0_in = 8'h01;
    push_exp("fresh_ready_b10", 32'h0);
    shift_beats(w, 0, 10);
    pop_exp(en, ev); checks++; if (32'(a_cfg_ready) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_ready, ev); end
    push_exp("fresh_ready_b11", 32'h1);
    shift_beats(w, 10, 1);
    pop_exp(en, ev); checks++; if (32'(a_cfg_ready) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_ready, ev); end
    push_exp("fresh_clb1_input", 32'h04);
    do_commit();
    pop_exp(en, ev); checks++; if (32'(a_clb1_input) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_clb1_input, ev); end
    push_exp("fresh_reg_clb1_input", 32'h04);
    tick();
    pop_exp(en, ev); checks++; if (32'(r_clb1_input) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, r_clb1_input, ev); end
  endtask

  task automatic test_reg_in();
    logic [CW-1:0] w;
    logic [2:0]    g;
    logic [31:0]   prev;
    logic [31:0]   nx;
    w = '0;
    w[5:0]  = 6'd33;
    w[11:6] = 6'd62;
    single0_in = 8'h01; double0_in = 8'h00; global_lines = 3'b000;
    shift_beats(w, 0, 11);
    do_commit();
    tick();
    prev = 32'h3C;
    push_exp("regin_settled", prev);
    pop_exp(en, ev); checks++; if (32'(r_clb0_input) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, r_clb0_input, ev); end
    for (int k = 0; k < 8; k++) begin
      g = (k % 2 == 1) ? 3'b010 : 3'b101;
      global_lines = g;
      nx = {26'h0, 4'hF, 1'b0, g[1]};
      push_exp("regin_pipe", nx);
      #1;
      checks++; if (32'(a_clb0_input) !== nx) begin errors++; $display("[TB] FAIL regin_comb: got %0h, expected %0h", a_clb0_input, nx); end
      checks++; if (32'(r_clb0_input) !== prev) begin errors++; $display("[TB] FAIL regin_hold: got %0h, expected %0h", r_clb0_input, prev); end
      tick();
      pop_exp(en, ev); checks++; if (32'(r_clb0_input) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, r_clb0_input, ev); end
      prev = ev;
    end
    push_exp("regin_err_clear", 32'h0);
    pop_exp(en, ev); checks++; if (32'(a_cfg_err) !== ev) begin errors++; $display("[TB] FAIL %s: got %0h, expected %0h", en, a_cfg_err, ev); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    single0_in = '0; single1_in = '0; double0_in = '0; double1_in = '0;
    global_lines = '0; clb0_output = '0; clb1_output = '0;
    clb0_cout = '0; clb1_cout = '0;
    cfg_in = '0; cfg_en = 1'b0; cfg_commit = 1'b0;
    tick();
    test_reset();
    test_commit();
    test_bias();
    test_illegal_commit();
    test_reset_midload();
    test_reg_in();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/connection_block_cfg.md
Name: connection_block_cfg

Overview:
- Next-generation unidirectional connection block for the island-style fabric.
- Routing matches the existing block: track-to-CLB input muxes, CLB-to-track output muxes with rotating bias, and a carry swap. CLB input and output counts are symmetric.
- Adds an on-block, daisy-chainable, double-buffered configuration store: a serial shadow chain plus an active register updated on commit.
- Adds an optional pipeline register on the CLB input path.

Parameters:
- WS, 8, single-length tracks per direction.
- WD, 8, double-length tracks per direction. Must be even.
- WG, 3, global lines. 0 is allowed.
- CLBIN, 6, inputs per CLB.
- CLBOUT, 1, outputs per CLB. Must be at least 1.
- CARRY, 1, carry width.
- CLBOS, 2, single tracks per direction driven by output muxes.
- CLBOS_BIAS, 0, single output-tap rotation; first tap = (CLBOS_BIAS*CLBOS)%WS.
- CLBOD, 2, double tracks per direction driven by output muxes; first tap = (CLBOD_BIAS*CLBOD)%(WD/2).
- CLBOD_BIAS, 0, double output-tap rotation.
- CLBX, 1, adds the opposite CLB's outputs to the input muxes.
- CHAIN_W, 8, configuration bits shifted per beat.
- REG_IN, 0, 1 = CLB inputs registered.
- Derived, SEL_IN, $clog2(2*(WS+WD)+WG+CLBX*CLBOUT).
- Derived, SEL_OUT, $clog2(2*CLBOUT+1).
- Derived, CONF_WIDTH, 2*CLBIN*SEL_IN + 2*SEL_OUT*(CLBOS+CLBOD).
- Derived, BEATS, ceil(CONF_WIDTH/CHAIN_W).
- Derived, PAD, BEATS*CHAIN_W.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- single0_in / single1_in, input, WS each, single tracks entering.
- single0_out / single1_out, output, WS each, single tracks leaving.
- double0_in / double1_in, input, WD each, double tracks entering.
- double0_out / double1_out, output, WD each, double tracks leaving.
- global, input, WG, global lines.
- clb0_output / clb1_output, input, CLBOUT each, CLB outputs.
- clb0_cout / clb1_cout, input, CARRY each, carry outs.
- clb0_input / clb1_input, output, CLBIN each, CLB inputs.
- clb0_cin / clb1_cin, output, CARRY each, carry ins.
- cfg_in, input, CHAIN_W, serial configuration beat.
- cfg_en, input, 1, shift strobe.
- cfg_out, output, CHAIN_W, chain out to the next block.
- cfg_commit, input, 1, copy shadow to active.
- cfg_ready, output, 1, shadow holds at least BEATS beats.
- cfg_err, output, 1, sticky illegal-commit flag.

Behaviour:
- Only clk and rst are used. One clock domain, and all state updates on the rising edge.
- Reset: shadow=0, active=0, beat count=0, cfg_ready=0, cfg_err=0, input pipeline registers=0. Reset overrides cfg_en and cfg_commit in the same cycle. Reset mid-load discards the partial shadow.
- Shift: when cfg_en=1, shadow <= {shadow[PAD-CHAIN_W-1:0], cfg_in} and count increments, saturating at BEATS.
- cfg_out = shadow[PAD-1:PAD-CHAIN_W], registered. After BEATS beats, the first beat sits at the top of the chain. Further beats shift onward to the next block.
- cfg_ready = (count==BEATS), registered.
- Commit is accepted when cfg_commit=1, cfg_ready=1 and cfg_en=0:
  - next edge: active <= shadow[CONF_WIDTH-1:0], count <= 0, cfg_ready <= 0;
  - the shadow is retained.
- Commit with cfg_ready=0, or with cfg_en=1: ignored, and cfg_err <= 1. cfg_err is cleared only by rst.
- Routing uses only the active register, so routing is glitch-free during shifting.
- Active layout, LSB first:
  - clb0 input selects, CLBIN x SEL_IN;
  - clb1 input selects, CLBIN x SEL_IN;
  - single dir0 selects, then single dir1 selects, CLBOS x SEL_OUT each;
  - double dir0 selects, then double dir1 selects, CLBOD x SEL_OUT each.
- Input mux index order:
  - single0_in[0..WS-1], single1_in, double0_in, double1_in;
  - then global (omitted if WG=0);
  - then the opposite CLB's outputs (only if CLBX).
- A select beyond the last legal index drives 0.
- Output mux: index 0 = straight-through track; 1..CLBOUT = clb0_output; CLBOUT+1..2*CLBOUT = clb1_output. Index beyond the last drives 0.
- Track wiring:
  - dir0 output mux k drives single1_out[t], where t = (tap+k)%WS.
  - dir1 output mux k drives single0_out[t].
  - Doubles work the same way within [0, WD/2).
  - All other tracks pass straight: x1_out = x0_in and x0_out = x1_in.
  - Upper double half [WD/2, WD) always passes straight.
- Carry: clb1_cin = clb0_cout, clb0_cin = clb1_cout. Purely combinational.
- Latency:
  - REG_IN=0: routing is fully combinational.
  - REG_IN=1: clb*_input are registered, with one cycle of latency, and reset to 0.
  - Track outputs are always combinational.
- After reset, the active config is 0. Every track passes straight and every CLB input = single0_in[0].

Test Plan:
Defaults apply: SEL_IN=6, SEL_OUT=2, CONF_WIDTH=88, BEATS=11.
- Reset, no config, single0_in=8'hA5, double1_in=8'h3C -> single1_out=8'hA5, double0_out=8'h3C, clb0_input=6'h3F, clb1_input=6'h3F, cfg_ready=0, cfg_err=0.
- Shift 11 beats so that clb0 input 0 select=35, then commit; set clb1_output=1 -> clb0_input[0]=1; cfg_ready goes 1 after beat 11 and 0 after commit; cfg_out shows beat 1.
- Configure dir0 single mux 0 select=2 with CLBOS_BIAS=3 (tap 6); clb1_output=1, single0_in=0 -> single1_out=8'h40, and the other bits pass straight.
- Assert cfg_commit after 5 beats -> active unchanged and cfg_err=1. Then commit together with cfg_en at beat 11 -> ignored, cfg_err stays 1.
- Assert rst at beat 7 -> count=0 and cfg_ready=0. A fresh 11-beat load then commits correctly.
- REG_IN=1: select global[1] (index 33) and toggle global -> clb input follows one cycle later. A select value of 62 -> input=0.
